// File: rtl/mode_register.sv
// mode_register: word-wide multi-function register (clear, load, increment,
// decrement, shift right, shift left, hold) with a registered one-cycle
// boundary flag. Fixed request priority: cl > ld > inc > dec > sr > sl > hold.
//
// Optional build macro: MODE_REGISTER_SATURATE_EN
//   undefined (default): inc/dec wrap modulo 2^DATA_WIDTH, ovf pulses on wrap.
//   defined            : inc/dec stick at all-ones/zero, ovf pulses at the bound.
module mode_register #(
    parameter int          DATA_WIDTH  = 4,
    parameter int unsigned RESET_VALUE = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cl,
    input  logic                  ld,
    input  logic [DATA_WIDTH-1:0] in,
    input  logic                  inc,
    input  logic                  dec,
    input  logic                  sr,
    input  logic                  ir,
    input  logic                  sl,
    input  logic                  il,
    output logic [DATA_WIDTH-1:0] out,
    output logic                  ovf
);

    // Reset word, truncated (or zero-extended) to the register width.
    localparam logic [DATA_WIDTH-1:0] RESET_WORD = DATA_WIDTH'(RESET_VALUE);
    localparam logic [DATA_WIDTH-1:0] ONE        = DATA_WIDTH'(1);

    typedef enum logic [2:0] {
        OP_HOLD,
        OP_CLEAR,
        OP_LOAD,
        OP_INC,
        OP_DEC,
        OP_SHR,
        OP_SHL
    } op_e;

    logic [DATA_WIDTH-1:0] out_q, out_d;
    logic                  ovf_q, ovf_d;
    op_e                   op;
    logic                  at_max;
    logic                  at_min;

    assign at_max = &out_q;
    assign at_min = ~|out_q;

    // Priority encoder: pick the single operation that takes effect this edge.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        op = OP_HOLD;
        if (cl)       op = OP_CLEAR;
        else if (ld)  op = OP_LOAD;
        else if (inc) op = OP_INC;
        else if (dec) op = OP_DEC;
        else if (sr)  op = OP_SHR;
        else if (sl)  op = OP_SHL;
    end

    // Next-state datapath: new register contents and boundary flag.
    always_comb begin
        out_d = out_q;
        ovf_d = 1'b0;
        unique case (op)
            OP_CLEAR: out_d = '0;
            OP_LOAD:  out_d = in;
            OP_INC: begin
                ovf_d = at_max;
`ifdef MODE_REGISTER_SATURATE_EN
                out_d = at_max ? out_q : out_q + ONE;
`else
                out_d = out_q + ONE;
`endif
            end
            OP_DEC: begin
                ovf_d = at_min;
`ifdef MODE_REGISTER_SATURATE_EN
                out_d = at_min ? out_q : out_q - ONE;
`else
                out_d = out_q - ONE;
`endif
            end
            OP_SHR:  out_d = {ir, out_q[DATA_WIDTH-1:1]};
            OP_SHL:  out_d = {out_q[DATA_WIDTH-2:0], il};
            default: out_d = out_q;
        endcase
    end

    // State register; asynchronous reset overrides any request.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (!rst_n) begin
            out_q <= RESET_WORD;
            ovf_q <= 1'b0;
        end else begin
            out_q <= out_d;
            ovf_q <= ovf_d;
        end
    end

    assign out = out_q;
    assign ovf = ovf_q;

endmodule
